fpga_config_loader: RTL

Parametrised configuration loader for the FPGA fabric. It accepts a word-serial bitstream over a valid/ready stream into a shadow register. When the last word arrives, it atomically commits the shadow contents to the routing, switch, logic and IO select buses. It sits between the external programming interface and the fabric top, and replaces hand-driven flat select buses with a loadable, geometry-generic configuration store.

---
 rtl/fpga_config_loader_if.sv | 44 ++++
 rtl/fpga_config_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fpga_config_loader_if.sv
// Bitstream stream and active-configuration bundle between the programming host and the loader.
// Widths follow the fabric geometry parameters and must match the loader instance.
interface fpga_config_loader_if #(
    parameter int FPGA_WIDTH  = 5,
    parameter int FPGA_HEIGHT = 5,
    parameter int WIRE_WIDTH  = 3,
    parameter int WORD_WIDTH  = 32
);
    localparam int BRB_BITS  = FPGA_WIDTH * FPGA_HEIGHT * WIRE_WIDTH * 12;
    localparam int BSB_BITS  = (FPGA_WIDTH - 1) * (FPGA_HEIGHT - 1) * WIRE_WIDTH * WIRE_WIDTH * 12;
    localparam int LB_BITS   = (FPGA_WIDTH - 1) * (FPGA_HEIGHT - 1) * 5;
    localparam int LRIO_BITS = 6 * FPGA_HEIGHT;
    localparam int TBIO_BITS = 6 * FPGA_WIDTH;

    logic                  start;
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic                  cfg_valid;
    logic [BRB_BITS-1:0]   brbselect;
    logic [BSB_BITS-1:0]   bsbselect;
    logic [LB_BITS-1:0]    lbselect;
    logic [LRIO_BITS-1:0]  leftioselect;
    logic [LRIO_BITS-1:0]  rightioselect;
    logic [TBIO_BITS-1:0]  topioselect;
    logic [TBIO_BITS-1:0]  bottomioselect;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, busy, done, error, cfg_valid,
        input  brbselect, bsbselect, lbselect,
        input  leftioselect, rightioselect, topioselect, bottomioselect
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, busy, done, error, cfg_valid,
        output brbselect, bsbselect, lbselect,
        output leftioselect, rightioselect, topioselect, bottomioselect
    );
endinterface

// File: rtl/fpga_config_loader.sv
// Word-serial configuration loader: fills a shadow image, then commits it atomically to the fabric selects.
// Optional trailing XOR checksum word is enabled by defining CFG_CRC_EN.
module fpga_config_loader #(
    parameter int FPGA_WIDTH  = 5,
    parameter int FPGA_HEIGHT = 5,
    parameter int WIRE_WIDTH  = 3,
    parameter int WORD_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    fpga_config_loader_if.slave     bus
);
    localparam int BRB_BITS  = FPGA_WIDTH * FPGA_HEIGHT * WIRE_WIDTH * 12;
    localparam int BSB_BITS  = (FPGA_WIDTH - 1) * (FPGA_HEIGHT - 1) * WIRE_WIDTH * WIRE_WIDTH * 12;
    localparam int LB_BITS   = (FPGA_WIDTH - 1) * (FPGA_HEIGHT - 1) * 5;
    localparam int LRIO_BITS = 6 * FPGA_HEIGHT;
    localparam int TBIO_BITS = 6 * FPGA_WIDTH;
    localparam int TOTAL     = BRB_BITS + BSB_BITS + LB_BITS + 2 * LRIO_BITS + 2 * TBIO_BITS;
    localparam int NWORDS    = (TOTAL + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int CNT_W     = $clog2(NWORDS + 1);
    localparam int LAST_W    = TOTAL - (NWORDS - 1) * WORD_WIDTH;
    localparam int OFF_BSB   = BRB_BITS;
    localparam int OFF_LB    = OFF_BSB + BSB_BITS;
    localparam int OFF_LIO   = OFF_LB + LB_BITS;
    localparam int OFF_RIO   = OFF_LIO + LRIO_BITS;
    localparam int OFF_TIO   = OFF_RIO + LRIO_BITS;
    localparam int OFF_BIO   = OFF_TIO + TBIO_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT
`ifdef CFG_CRC_EN
        , S_CHECK,
        S_FAIL
`endif
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 in_ready_q, busy_q, done_q, cfg_valid_q;
    logic [BRB_BITS-1:0]  brb_q;
    logic [BSB_BITS-1:0]  bsb_q;
    logic [LB_BITS-1:0]   lb_q;
    logic [LRIO_BITS-1:0] lio_q, rio_q;
    logic [TBIO_BITS-1:0] tio_q, bio_q;

    // The last word only carries LAST_W meaningful bits; the rest of it is dropped on write.
    logic [WORD_WIDTH-1:0] shadow_q [NWORDS-1];
    logic [LAST_W-1:0]     shadow_last_q;
    logic [TOTAL-1:0]      image;

    logic accept, last_word, load_word;
    assign accept    = bus.in_valid && in_ready_q;
    assign last_word = (cnt_q == CNT_W'(NWORDS - 1));
    assign load_word = accept && !bus.start && (state_q == S_LOAD);

`ifdef CFG_CRC_EN
    logic [WORD_WIDTH-1:0] csum_q, csum_d;
    logic                  error_q;
    assign csum_d = csum_q ^ bus.in_data;
`endif

    always_ff @(posedge clk) begin
        if (load_word) begin
            if (last_word) shadow_last_q <= bus.in_data[LAST_W-1:0];
            else           shadow_q[cnt_q] <= bus.in_data;
        end
    end

    always_comb begin
        image = '0;
        for (int k = 0; k < NWORDS - 1; k++) image[k*WORD_WIDTH +: WORD_WIDTH] = shadow_q[k];
        image[TOTAL-1 -: LAST_W] = shadow_last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_valid_q <= 1'b0;
            brb_q       <= '0;
            bsb_q       <= '0;
            lb_q        <= '0;
            lio_q       <= '0;
            rio_q       <= '0;
            tio_q       <= '0;
            bio_q       <= '0;
`ifdef CFG_CRC_EN
            csum_q      <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef CFG_CRC_EN
            error_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q    <= S_LOAD;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
`ifdef CFG_CRC_EN
                        csum_q     <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    // A restart wins over a word presented in the same cycle.
                    if (bus.start) begin
                        cnt_q <= '0;
`ifdef CFG_CRC_EN
                        csum_q <= '0;
`endif
                    end else if (accept) begin
`ifdef CFG_CRC_EN
                        csum_q <= csum_d;
`endif
                        if (last_word) begin
                            cnt_q <= '0;
`ifdef CFG_CRC_EN
                            state_q <= S_CHECK;
`else
                            state_q    <= S_COMMIT;
                            in_ready_q <= 1'b0;
`endif
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
`ifdef CFG_CRC_EN
                S_CHECK: begin
                    if (bus.start) begin
                        state_q <= S_LOAD;
                        csum_q  <= '0;
                    end else if (accept) begin
                        in_ready_q <= 1'b0;
                        csum_q     <= '0;
                        state_q    <= (bus.in_data == csum_q) ? S_COMMIT : S_FAIL;
                    end
                end
                S_FAIL: begin
                    error_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
`endif
                S_COMMIT: begin
                    brb_q       <= image[0 +: BRB_BITS];
                    bsb_q       <= image[OFF_BSB +: BSB_BITS];
                    lb_q        <= image[OFF_LB +: LB_BITS];
                    lio_q       <= image[OFF_LIO +: LRIO_BITS];
                    rio_q       <= image[OFF_RIO +: LRIO_BITS];
                    tio_q       <= image[OFF_TIO +: TBIO_BITS];
                    bio_q       <= image[OFF_BIO +: TBIO_BITS];
                    cfg_valid_q <= 1'b1;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.cfg_valid      = cfg_valid_q;
    assign bus.brbselect      = brb_q;
    assign bus.bsbselect      = bsb_q;
    assign bus.lbselect       = lb_q;
    assign bus.leftioselect   = lio_q;
    assign bus.rightioselect  = rio_q;
    assign bus.topioselect    = tio_q;
    assign bus.bottomioselect = bio_q;
`ifdef CFG_CRC_EN
    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif
endmodule
